bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Memory-bus arbiter between the CPU and the DMA controller, implementing the BR/BG handshake on the grant side. It lets any in-flight CPU access finish before granting, steers the shared memory address bus to the current owner, and stalls CPU issue while DMA owns the bus. It also latches the DMA completion interrupt until the CPU acknowledges it. It sits between the CPU memory port, the DMA controller and memory.

## Interface
- WORD_SIZE, 16, address width
- MAX_HOLD, 32, DMA hold cycles before timeout_err is flagged (≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- br  in  1  bus request from DMA controller (level)
- dma_use_bus  in  1  DMA is driving an address this cycle
- dma_address  in  WORD_SIZE  DMA address
- dma_irq  in  1  one-cycle DMA completion pulse
- cpu_busy  in  1  CPU memory access in flight (already issued)
- cpu_address  in  WORD_SIZE  CPU address
- irq_ack  in  1  CPU acknowledge of pending DMA interrupt
- bg  out  1  bus grant to DMA (registered)
- cpu_stall  out  1  CPU must not issue a new memory access
- bus_sel  out  1  1 = DMA drives mem_address
- mem_address  out  WORD_SIZE  muxed address to memory
- irq_pending  out  1  latched DMA interrupt to CPU
- grant_count  out  8  number of grants issued, wraps 255→0
- timeout_err  out  1  sticky: a grant exceeded MAX_HOLD cycles

## Operation
- FSM states: S_CPU (CPU owns the bus), S_DRAIN (request seen, CPU access completing), S_DMA (bg=1), S_RELEASE (one-cycle turnaround).
- S_CPU: br=1 & cpu_busy=0 → S_DMA. br=1 & cpu_busy=1 → S_DRAIN. Otherwise stay.
- S_DRAIN: br=0 (DMA abort) → S_CPU. br=1 & cpu_busy=0 → S_DMA. Otherwise stay.
- S_DMA: br=0 → S_RELEASE; otherwise stay. A grant is never revoked by the arbiter.
- S_RELEASE → S_CPU unconditionally; a new br is first honoured from S_CPU.
- bg = (state==S_DMA), registered.
- cpu_stall = (state!=S_CPU). Stall blocks only new issues; an in-flight access still completes.
- bus_sel = (state==S_DMA) & dma_use_bus. mem_address = bus_sel ? dma_address : cpu_address (combinational).
- grant_count increments on every entry into S_DMA.
- hold_count (internal) clears on entry into S_DMA and increments each cycle in S_DMA, saturating at MAX_HOLD. When it reaches MAX_HOLD, timeout_err is set and stays set until reset.
- irq_pending: set on dma_irq, cleared on irq_ack. If both occur in the same cycle, set wins.
- Reset values: state=S_CPU, bg=0, cpu_stall=0, bus_sel=0, irq_pending=0, grant_count=0, timeout_err=0, hold_count=0.

## Timing
- br and cpu_busy are sampled at posedge. With cpu_busy=0, bg rises 1 cycle after br.
- Drain case: bg rises on the edge after cpu_busy is first sampled low.
- bg falls on the edge after br is sampled low. bg=0 holds at least 1 cycle before any new grant (S_RELEASE).
- cpu_stall rises with entry into S_DRAIN/S_DMA and falls on return to S_CPU, i.e. 2 cycles after br is sampled low.
- irq_pending rises 1 cycle after the dma_irq pulse.
- Async reset mid-grant: bg, cpu_stall and bus_sel drop immediately. irq_pending is lost.

## Structure
- Shared package arb_pkg: state encoding (S_CPU=2'd0, S_DRAIN=2'd1, S_DMA=2'd2, S_RELEASE=2'd3), WORD_SIZE default.
- One sub-module, bus_hold_timer: saturating hold counter plus sticky timeout_err, parameterised by MAX_HOLD.

## Test plan
- Idle CPU: br↑ at cycle 0 → bg=1 at cycle 1. br↓ at cycle 14 → bg=0 at cycle 15, cpu_stall=0 at cycle 16, grant_count=1.
- Drain: cpu_busy=1 for cycles 0–3, br↑ at cycle 0 → state S_DRAIN, cpu_stall=1 at cycle 1, bg=1 at cycle 5.
- Abort: br↑ then br↓ while cpu_busy=1 → returns to S_CPU, bg never asserted, grant_count unchanged.
- Steering: in S_DMA with dma_use_bus=1, dma_address=16'h0040 → mem_address=16'h0040. With dma_use_bus=0 → mem_address=cpu_address.
- IRQ: dma_irq pulse → irq_pending=1 next cycle. irq_ack together with a new dma_irq → irq_pending stays 1. A lone irq_ack → 0.
- Timeout/reset: MAX_HOLD=4, hold br for 6 cycles → timeout_err=1 and stays 1 after release. reset_n↓ mid-grant → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the CPU/DMA memory-bus arbiter: state encoding,
// default address width and the grant-entry helper.
package arb_pkg;

  localparam int WORD_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_DRAIN   = 2'd1,
    S_DMA     = 2'd2,
    S_RELEASE = 2'd3
  } arb_state_e;

  // True on the cycle the arbiter moves into the DMA-owned state.
  function automatic logic is_grant_entry(arb_state_e cur, arb_state_e nxt);
    return (cur != S_DMA) && (nxt == S_DMA);
  endfunction

endpackage

// File: rtl/bus_hold_timer.sv
// Counts how long the DMA has held the bus in the current grant and raises a
// sticky timeout once the hold reaches MAX_HOLD cycles.
module bus_hold_timer #(
  parameter int MAX_HOLD = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic active,
  output logic timeout_err
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

  logic [HW-1:0] hold_count_r;
  logic [HW-1:0] hold_count_s;
  logic          timeout_err_r;

  // Next hold count: clear on a fresh grant, saturate at the limit.
  always_comb begin
    hold_count_s = hold_count_r;
    if (start) begin
      hold_count_s = HOLD_ZERO;
    end else if (active && (hold_count_r != HOLD_MAX)) begin
      hold_count_s = hold_count_r + HOLD_ONE;
    end else begin
      hold_count_s = hold_count_r;
    end
  end

  // Hold counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_count_r  <= HOLD_ZERO;
      timeout_err_r <= 1'b0;
    end else begin
      hold_count_r  <= hold_count_s;
      timeout_err_r <= timeout_err_r | (hold_count_s == HOLD_MAX);
    end
  end

  assign timeout_err = timeout_err_r;

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA memory-bus arbiter: BR/BG grant handshake with CPU drain, address
// steering, CPU stall, DMA interrupt latch and grant statistics.
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MAX_HOLD  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 br,
  input  logic                 dma_use_bus,
  input  logic [WORD_SIZE-1:0] dma_address,
  input  logic                 dma_irq,
  input  logic                 cpu_busy,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic                 irq_ack,
  output logic                 bg,
  output logic                 cpu_stall,
  output logic                 bus_sel,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic                 irq_pending,
  output logic [7:0]           grant_count,
  output logic                 timeout_err
);

  arb_state_e state_r;
  arb_state_e state_s;
  logic       bg_r;
  logic       cpu_stall_r;
  logic       irq_pending_r;
  logic [7:0] grant_count_r;
  logic       grant_entry_s;
  logic       in_dma_s;

  // Next-state decode; a grant is only ever ended by the DMA dropping br.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_CPU: begin
        if (br && !cpu_busy) begin
          state_s = S_DMA;
        end else if (br) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_CPU;
        end
      end
      S_DRAIN: begin
        if (!br) begin
          state_s = S_CPU;
        end else if (!cpu_busy) begin
          state_s = S_DMA;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DMA: begin
        if (!br) begin
          state_s = S_RELEASE;
        end else begin
          state_s = S_DMA;
        end
      end
      S_RELEASE: state_s = S_CPU;
      default:   state_s = S_CPU;
    endcase
  end

  assign grant_entry_s = is_grant_entry(state_r, state_s);
  assign in_dma_s      = (state_r == S_DMA);

  // State register with registered grant/stall decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_CPU;
      bg_r        <= 1'b0;
      cpu_stall_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      bg_r        <= (state_s == S_DMA);
      cpu_stall_r <= (state_s != S_CPU);
    end
  end

  // Grant statistics (free-running wrap) and DMA interrupt latch; set beats ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_count_r <= 8'd0;
      irq_pending_r <= 1'b0;
    end else begin
      if (grant_entry_s) begin
        grant_count_r <= grant_count_r + 8'd1;
      end
      if (dma_irq) begin
        irq_pending_r <= 1'b1;
      end else if (irq_ack) begin
        irq_pending_r <= 1'b0;
      end
    end
  end

  bus_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (grant_entry_s),
    .active      (in_dma_s),
    .timeout_err (timeout_err)
  );

  // bg_r mirrors state==S_DMA, so steering follows the grant with no extra delay.
  assign bus_sel     = bg_r & dma_use_bus;
  assign mem_address = bus_sel ? dma_address : cpu_address;
  assign bg          = bg_r;
  assign cpu_stall   = cpu_stall_r;
  assign irq_pending = irq_pending_r;
  assign grant_count = grant_count_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues cycle-tagged expectations,
// a monitor compares them against the DUT each cycle.
module tb_bus_arbiter;

  localparam int WS = 16;

  typedef enum int {SIG_BG, SIG_STALL, SIG_SEL, SIG_ADDR, SIG_IRQ, SIG_GCNT, SIG_TERR} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } sb_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          br = 1'b0;
  logic          dma_use_bus = 1'b0;
  logic [WS-1:0] dma_address = 16'h0000;
  logic          dma_irq = 1'b0;
  logic          cpu_busy = 1'b0;
  logic [WS-1:0] cpu_address = 16'h0000;
  logic          irq_ack = 1'b0;
  logic          bg;
  logic          cpu_stall;
  logic          bus_sel;
  logic [WS-1:0] mem_address;
  logic          irq_pending;
  logic [7:0]    grant_count;
  logic          timeout_err;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  sb_t sb_q[$];

  bus_arbiter #(.WORD_SIZE(WS), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .br          (br),
    .dma_use_bus (dma_use_bus),
    .dma_address (dma_address),
    .dma_irq     (dma_irq),
    .cpu_busy    (cpu_busy),
    .cpu_address (cpu_address),
    .irq_ack     (irq_ack),
    .bg          (bg),
    .cpu_stall   (cpu_stall),
    .bus_sel     (bus_sel),
    .mem_address (mem_address),
    .irq_pending (irq_pending),
    .grant_count (grant_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] read_sig(sig_e s);
    case (s)
      SIG_BG:    return {31'd0, bg};
      SIG_STALL: return {31'd0, cpu_stall};
      SIG_SEL:   return {31'd0, bus_sel};
      SIG_ADDR:  return {16'd0, mem_address};
      SIG_IRQ:   return {31'd0, irq_pending};
      SIG_GCNT:  return {24'd0, grant_count};
      SIG_TERR:  return {31'd0, timeout_err};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int off, input sig_e s, input logic [31:0] v);
    sb_t e;
    e.cyc = cyc + off;
    e.sig = s;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always begin
    @(negedge clk);
    #2;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check(sb_q[i].sig.name(), read_sig(sb_q[i].sig), sb_q[i].val);
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        check({"missed_", sb_q[i].sig.name()}, 32'hFFFF_FFFF, sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    expect_at(0, SIG_BG, 32'd0);
    expect_at(0, SIG_STALL, 32'd0);
    expect_at(0, SIG_SEL, 32'd0);
    expect_at(0, SIG_IRQ, 32'd0);
    expect_at(0, SIG_GCNT, 32'd0);
    expect_at(0, SIG_TERR, 32'd0);
    tick();
  endtask

  initial begin
    do_reset();

    // Idle CPU grant, steering, timeout at hold limit 4, release turnaround.
    tick();
    br = 1'b1; dma_use_bus = 1'b1; dma_address = 16'hBEEF; cpu_address = 16'h1234;
    expect_at(0, SIG_BG, 32'd0);
    expect_at(0, SIG_STALL, 32'd0);
    expect_at(0, SIG_SEL, 32'd0);
    expect_at(0, SIG_ADDR, 32'h1234);
    expect_at(1, SIG_BG, 32'd1);
    expect_at(1, SIG_STALL, 32'd1);
    expect_at(1, SIG_GCNT, 32'd1);
    expect_at(4, SIG_TERR, 32'd0);
    expect_at(5, SIG_TERR, 32'd1);
    expect_at(5, SIG_SEL, 32'd1);
    expect_at(5, SIG_ADDR, 32'h0040);
    expect_at(6, SIG_SEL, 32'd0);
    expect_at(6, SIG_ADDR, 32'h1234);
    expect_at(14, SIG_BG, 32'd1);
    expect_at(15, SIG_BG, 32'd0);
    expect_at(15, SIG_STALL, 32'd1);
    expect_at(16, SIG_STALL, 32'd0);
    expect_at(16, SIG_GCNT, 32'd1);
    expect_at(16, SIG_TERR, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      br          = (i < 14);
      dma_use_bus = (i == 5);
      dma_address = (i == 5) ? 16'h0040 : 16'hBEEF;
    end
    tick();

    do_reset();

    // Drain: CPU access in flight for cycles 0-3.
    tick();
    br = 1'b1; cpu_busy = 1'b1;
    expect_at(1, SIG_STALL, 32'd1);
    expect_at(1, SIG_BG, 32'd0);
    expect_at(4, SIG_BG, 32'd0);
    expect_at(4, SIG_STALL, 32'd1);
    expect_at(5, SIG_BG, 32'd1);
    expect_at(5, SIG_GCNT, 32'd1);
    expect_at(7, SIG_BG, 32'd0);
    expect_at(8, SIG_STALL, 32'd0);
    expect_at(8, SIG_TERR, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      cpu_busy = (i <= 3);
      br       = (i < 6);
    end
    tick();

    // Abort while draining: no grant, count unchanged.
    tick();
    br = 1'b1; cpu_busy = 1'b1;
    expect_at(1, SIG_STALL, 32'd1);
    expect_at(1, SIG_BG, 32'd0);
    expect_at(2, SIG_STALL, 32'd0);
    expect_at(2, SIG_BG, 32'd0);
    expect_at(3, SIG_BG, 32'd0);
    expect_at(3, SIG_GCNT, 32'd1);
    tick();
    br = 1'b0;
    tick();
    tick();
    cpu_busy = 1'b0;
    tick();

    // Interrupt latch: set, set-beats-ack, lone ack clears.
    tick();
    dma_irq = 1'b1;
    expect_at(0, SIG_IRQ, 32'd0);
    expect_at(1, SIG_IRQ, 32'd1);
    tick();
    dma_irq = 1'b0;
    tick();
    dma_irq = 1'b1; irq_ack = 1'b1;
    expect_at(1, SIG_IRQ, 32'd1);
    tick();
    dma_irq = 1'b0;
    expect_at(1, SIG_IRQ, 32'd0);
    tick();
    irq_ack = 1'b0;
    expect_at(1, SIG_IRQ, 32'd0);
    tick();
    tick();

    // Asynchronous reset in the middle of a grant.
    tick();
    br = 1'b1;
    expect_at(1, SIG_BG, 32'd1);
    tick();
    dma_irq = 1'b1;
    expect_at(1, SIG_IRQ, 32'd1);
    tick();
    dma_irq = 1'b0; dma_use_bus = 1'b1; dma_address = 16'h0040; cpu_address = 16'h1234;
    expect_at(0, SIG_SEL, 32'd1);
    expect_at(0, SIG_ADDR, 32'h0040);
    expect_at(0, SIG_GCNT, 32'd2);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_bg", {31'd0, bg}, 32'd0);
    check("async_stall", {31'd0, cpu_stall}, 32'd0);
    check("async_sel", {31'd0, bus_sel}, 32'd0);
    check("async_addr", {16'd0, mem_address}, 32'h1234);
    check("async_irq", {31'd0, irq_pending}, 32'd0);
    check("async_gcnt", {24'd0, grant_count}, 32'd0);
    check("async_terr", {31'd0, timeout_err}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1; br = 1'b0; dma_use_bus = 1'b0;
    tick();
    tick();

    while (sb_q.size() > 0) begin
      check({"unchecked_", sb_q[0].sig.name()}, 32'hFFFF_FFFF, sb_q[0].val);
      void'(sb_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
